// File: rtl/phoenix_input_buffer_pkg.sv
// phoenix_input_buffer_pkg
//   Shared definitions for the router input buffer: default flit width and
//   buffer depth, the buffer FSM state encoding, and a small state helper.
//   Optional build macro used by the buffer files: PHOENIX_BUF_OCCUPANCY_EN.
package phoenix_input_buffer_pkg;

  localparam int TAM_FLIT_DEF   = 16;
  localparam int TAM_BUFFER_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HDR     = 3'd2,
    S_SIZE    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_END     = 3'd5
  } buf_state_t;

  // States in which the connection is held and flits are offered to the crossbar.
  function automatic logic is_streaming(input buf_state_t s);
    return (s == S_HDR) || (s == S_SIZE) || (s == S_PAYLOAD);
  endfunction

endpackage

// File: rtl/phoenix_flit_fifo.sv
// phoenix_flit_fifo
//   Flit storage for one input port: circular buffer with wrapping read/write
//   pointers and an occupancy counter. Full/empty come only from the counter.
//   A pop does not free a slot for a write in the same cycle.
//   Build macro PHOENIX_BUF_OCCUPANCY_EN adds the count output.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   wr_en, wr_data    write request and flit (ignored while full)
//   rd_en             pop the head flit (ignored while empty)
//   full, empty       occupancy flags
//   head              head flit, zero while empty
//   count             (optional) registered flit count, 0..DEPTH
module phoenix_flit_fifo
  import phoenix_input_buffer_pkg::*;
#(
  parameter int WIDTH = TAM_FLIT_DEF,
  parameter int DEPTH = TAM_BUFFER_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head
`ifdef PHOENIX_BUF_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_wr;
  logic             do_rd;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Stale entries stay in memory after a flush, so the head is masked while empty.
  assign head = empty ? '0 : mem[rd_ptr];

`ifdef PHOENIX_BUF_OCCUPANCY_EN
  assign count = cnt;
`endif

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/phoenix_input_buffer.sv
// phoenix_input_buffer
//   Per-port router input buffer. Queues incoming flits, requests header
//   routing (h / ack_h), then streams header, size flit and payload to the
//   crossbar and releases the connection after the last flit.
//   Build macro PHOENIX_BUF_OCCUPANCY_EN adds occupancy and sticky overflow.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   rx, data_in       upstream flit valid / flit (honoured only with credit_o)
//   credit_o          buffer not full
//   h, ack_h          routing request / one-cycle grant
//   data_av, data     flit available / FIFO head flit
//   data_ack          crossbar consumed the current flit
//   sender            connection held, grant through last flit
//   occupancy         (optional) registered flit count
//   overflow          (optional) sticky: rx seen while full
//
// state     | meaning
// S_IDLE    | waiting for a flit in the FIFO
// S_REQ     | h asserted, waiting for ack_h
// S_HDR     | offering the header flit
// S_SIZE    | offering the size flit, loads payload counter on pop
// S_PAYLOAD | offering payload flits, counter counts down per pop
// S_END     | connection released for one cycle
module phoenix_input_buffer
  import phoenix_input_buffer_pkg::*;
#(
  parameter int TAM_FLIT   = TAM_FLIT_DEF,
  parameter int TAM_BUFFER = TAM_BUFFER_DEF,
  parameter int CNT_W      = TAM_FLIT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rx,
  input  logic [TAM_FLIT-1:0]          data_in,
  output logic                         credit_o,
  output logic                         h,
  input  logic                         ack_h,
  output logic                         data_av,
  output logic [TAM_FLIT-1:0]          data,
  input  logic                         data_ack,
  output logic                         sender
`ifdef PHOENIX_BUF_OCCUPANCY_EN
  ,
  output logic [$clog2(TAM_BUFFER):0]  occupancy,
  output logic                         overflow
`endif
);

  buf_state_t       state;
  buf_state_t       state_nx;
  logic [CNT_W-1:0] payload_cnt;
  logic             full;
  logic             empty;
  logic             pop;

  phoenix_flit_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (TAM_BUFFER)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rx),
    .wr_data (data_in),
    .rd_en   (pop),
    .full    (full),
    .empty   (empty),
    .head    (data)
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    ,
    .count   (occupancy)
`endif
  );

  assign credit_o = !full;
  assign pop      = data_av && data_ack;

`ifdef PHOENIX_BUF_OCCUPANCY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           overflow <= 1'b0;
    else if (rx && full) overflow <= 1'b1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!empty) state_nx = S_REQ;
      S_REQ:     if (ack_h)  state_nx = S_HDR;
      S_HDR:     if (pop)    state_nx = S_SIZE;
      S_SIZE:    if (pop)    state_nx = (data[CNT_W-1:0] == '0) ? S_END : S_PAYLOAD;
      S_PAYLOAD: if (pop && payload_cnt == CNT_W'(1)) state_nx = S_END;
      S_END:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    h       = (state == S_REQ);
    sender  = is_streaming(state);
    data_av = sender && !empty;
  end

  // Down-counter of payload flits still to be sent; loaded from the size flit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      payload_cnt <= '0;
    end else if (pop) begin
      if (state == S_SIZE)         payload_cnt <= data[CNT_W-1:0];
      else if (state == S_PAYLOAD) payload_cnt <= payload_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_phoenix_input_buffer.sv
module tb_phoenix_input_buffer;
  localparam int W     = 16;
  localparam int DEPTH = 16;

  typedef logic [W-1:0] flit_q_t[$];

  logic         clock = 1'b0;
  logic         reset;
  logic         rx;
  logic [W-1:0] data_in;
  logic         credit_o;
  logic         h;
  logic         ack_h;
  logic         data_av;
  logic [W-1:0] data;
  logic         data_ack;
  logic         sender;
`ifdef PHOENIX_BUF_OCCUPANCY_EN
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;
`endif

  phoenix_input_buffer #(
    .TAM_FLIT   (W),
    .TAM_BUFFER (DEPTH),
    .CNT_W      (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data_in   (data_in),
    .credit_o  (credit_o),
    .h         (h),
    .ack_h     (ack_h),
    .data_av   (data_av),
    .data      (data),
    .data_ack  (data_ack),
    .sender    (sender)
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    ,
    .occupancy (occupancy),
    .overflow  (overflow)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  flit_q_t popped;

  // Record every flit handed to the crossbar (values before the edge).
  always @(posedge clock) begin
    if (!reset && data_av === 1'b1 && data_ack === 1'b1) popped.push_back(data);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    rx = 0; ack_h = 0; data_ack = 0; data_in = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    popped.delete();
  endtask

  task automatic wait_h(input string tag);
    int n = 0;
    while (h !== 1'b1 && n < 50) begin tick(); n++; end
    chk(tag, h, 1);
  endtask

  task automatic grant();
    ack_h = 1; tick(); ack_h = 0;
  endtask

  task automatic wait_pops(input string tag, input int n);
    int k = 0;
    while (popped.size() < n && k < 300) begin tick(); k++; end
    chk(tag, popped.size(), n);
  endtask

  task automatic write_seq(input flit_q_t s);
    for (int i = 0; i < s.size(); i++) begin
      rx = 1; data_in = s[i]; tick();
    end
    rx = 0;
  endtask

  task automatic chk_seq(input string tag, input flit_q_t e);
    chk({tag, "_len"}, popped.size(), e.size());
    for (int i = 0; i < e.size() && i < popped.size(); i++) chk(tag, popped[i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flit_q_t e;
    int k;
    reset = 1; rx = 0; ack_h = 0; data_ack = 0; data_in = '0;

    // reset then idle
    do_reset();
    chk("rst_data", data, 0);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow, 0);
`endif
    for (int i = 0; i < 20; i++) begin
      chk("idle_credit", credit_o, 1);
      chk("idle_h", h, 0);
      chk("idle_av", data_av, 0);
      chk("idle_sender", sender, 0);
      tick();
    end

    // single packet, immediate grant
    do_reset();
    rx = 1; data_in = 16'h0011; tick();
    chk("pkt1_h_early", h, 0);
    data_in = 16'h0003; tick();
    chk("pkt1_h_latency", h, 1);
    data_in = 16'h00A1; ack_h = 1; tick(); ack_h = 0;
    chk("pkt1_h_drop", h, 0);
    chk("pkt1_sender_on", sender, 1);
    chk("pkt1_av_latency", data_av, 1);
    chk("pkt1_head", data, 16'h0011);
    data_in = 16'h00A2; data_ack = 1; tick();
    data_in = 16'h00A3; tick();
    rx = 0;
    wait_pops("pkt1_pops", 5);
    chk("pkt1_end_sender", sender, 0);
    chk("pkt1_end_av", data_av, 0);
    chk("pkt1_empty", credit_o, 1);
    tick();
    chk("pkt1_idle_h", h, 0);
    chk("pkt1_idle_sender", sender, 0);
    e = '{16'h0011, 16'h0003, 16'h00A1, 16'h00A2, 16'h00A3};
    chk_seq("pkt1_seq", e);
    data_ack = 0;

    // delayed grant
    do_reset();
    write_seq('{16'h0044, 16'h0001, 16'h00C1});
    wait_h("dly_h");
    for (int i = 0; i < 10; i++) begin
      chk("dly_h_hold", h, 1);
      chk("dly_av_low", data_av, 0);
      tick();
    end
    grant();
    data_ack = 1;
    wait_pops("dly_pops", 3);
    chk("dly_sender_off", sender, 0);
    e = '{16'h0044, 16'h0001, 16'h00C1};
    chk_seq("dly_seq", e);
    data_ack = 0;

    // full / backpressure
    do_reset();
    e.delete();
    e.push_back(16'h0055);
    e.push_back(16'h000E);
    for (int i = 0; i < 14; i++) e.push_back(16'h00D0 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      chk("full_credit_before", credit_o, 1);
      rx = 1; data_in = e[i]; tick();
    end
    rx = 0;
    chk("full_credit_16", credit_o, 0);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    chk("full_occ", occupancy, 16);
    chk("full_ovf_clear", overflow, 0);
`endif
    rx = 1; data_in = 16'hDEAD; tick(); rx = 0;
    chk("full_credit_17", credit_o, 0);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    chk("full_occ_17", occupancy, 16);
    chk("full_ovf_set", overflow, 1);
`endif
    wait_h("full_h");
    grant();
    data_ack = 1;
    wait_pops("full_pops", 16);
    tick();
    chk_seq("full_seq", e);
    chk("full_drained", credit_o, 1);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    chk("full_occ_drained", occupancy, 0);
    chk("full_ovf_sticky", overflow, 1);
`endif
    data_ack = 0;

    // size 0 packet followed by a back-to-back packet
    do_reset();
    write_seq('{16'h0022, 16'h0000, 16'h0033, 16'h0001, 16'h00B1});
    wait_h("sz0_h");
    grant();
    data_ack = 1;
    k = 0;
    while (sender === 1'b1 && k < 50) begin tick(); k++; end
    chk("sz0_end_after_size", popped.size(), 2);
    chk("sz0_av_low", data_av, 0);
    tick();
    chk("sz0_idle_h", h, 0);
    tick();
    chk("sz0_rereq_latency", h, 1);
    grant();
    wait_pops("sz0_pops", 5);
    e = '{16'h0022, 16'h0000, 16'h0033, 16'h0001, 16'h00B1};
    chk_seq("sz0_seq", e);
    data_ack = 0;

    // reset in the middle of the payload
    do_reset();
    write_seq('{16'h0066, 16'h0005, 16'h00E1, 16'h00E2, 16'h00E3, 16'h00E4, 16'h00E5});
    wait_h("mid_h");
    grant();
    data_ack = 1;
    wait_pops("mid_pops", 4);
    chk("mid_sender_before", sender, 1);
    reset = 1;
    #1;
    chk("mid_rst_credit", credit_o, 1);
    chk("mid_rst_h", h, 0);
    chk("mid_rst_av", data_av, 0);
    chk("mid_rst_sender", sender, 0);
    chk("mid_rst_data", data, 0);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
    chk("mid_rst_occ", occupancy, 0);
`endif
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_after_h", h, 0);
      chk("mid_after_av", data_av, 0);
    end
    data_ack = 0;

    // randomized traffic against a packet-level model
    do_reset();
    begin : rnd
      flit_q_t q;
      flit_q_t tx;
      logic [W-1:0] f;
      bit in_pkt;
      bit h_prev, ack_prev, ovf, w, p;
      int pos, rem, starve, n;
      in_pkt = 0; h_prev = 0; ack_prev = 0; ovf = 0; pos = 0; rem = 0; starve = 0;
      for (int c = 0; c < 4000; c++) begin
        chk("rnd_credit", credit_o, q.size() < DEPTH);
        chk("rnd_sender", sender, in_pkt);
        chk("rnd_av", data_av, in_pkt && q.size() > 0);
        if (in_pkt && q.size() > 0) chk("rnd_data", data, q[0]);
        if (in_pkt) chk("rnd_h_busy", h, 0);
        if (h_prev && !ack_prev) chk("rnd_h_hold", h, 1);
        if (!in_pkt && q.size() > 0 && h !== 1'b1) starve++;
        else starve = 0;
        chk("rnd_req_latency", starve <= 2, 1);
`ifdef PHOENIX_BUF_OCCUPANCY_EN
        chk("rnd_occ", occupancy, q.size());
        chk("rnd_ovf", overflow, ovf);
`endif
        if (tx.size() == 0) begin
          n = $urandom_range(0, 6);
          tx.push_back(W'($urandom));
          tx.push_back(W'(n));
          for (int i = 0; i < n; i++) tx.push_back(W'($urandom));
        end
        ack_h    = (h === 1'b1) && !in_pkt && ($urandom_range(0, 3) == 0);
        data_ack = ($urandom_range(0, 2) != 0);
        rx       = 0;
        data_in  = W'($urandom);
        if (q.size() < DEPTH) begin
          if ($urandom_range(0, 1) == 1) begin rx = 1; data_in = tx[0]; end
        end else if ($urandom_range(0, 7) == 0) begin
          rx = 1;
        end
        w = rx && (q.size() < DEPTH);
        p = in_pkt && (q.size() > 0) && data_ack;
        if (rx && q.size() >= DEPTH) ovf = 1;
        if (p) begin
          f = q.pop_front();
          if (pos == 0) pos = 1;
          else if (pos == 1) begin
            rem = int'(f);
            if (rem == 0) in_pkt = 0;
            else pos = 2;
          end else begin
            rem--;
            if (rem == 0) in_pkt = 0;
          end
        end
        if (w) begin
          q.push_back(data_in);
          void'(tx.pop_front());
        end
        if (ack_h) begin in_pkt = 1; pos = 0; end
        h_prev   = (h === 1'b1);
        ack_prev = ack_h;
        tick();
      end
      rx = 0; ack_h = 0; data_ack = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
